// File: rtl/deser8.sv
// deser8: strobed serial-to-parallel byte assembler with SOF framing,
// valid/ready output holding register and sticky overrun / frame-error flags.
module deser8 #(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_en,
    input  logic       in_sof,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic       frame_err,
    input  logic       clr_err
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_SHIFT = 1'b1;
    localparam int unsigned TO_M1    = (TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1);
    localparam logic [15:0] TO_LIM   = 16'(TO_M1);
    localparam bit          TO_EN    = (TIMEOUT != 32'd0);

    logic [0:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;

    logic [7:0]  sr_shift_s;
    logic        byte_done_s;
    logic        set_ferr_s;
    logic        set_ovr_s;
    logic        accept_s;

    // Bits are shifted toward the end that the first bit must finally occupy.
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
        logic [7:0] r;
        if (MSB_FIRST) begin
            r = {sr[6:0], b};
        end else begin
            r = {b, sr[7:1]};
        end
        return r;
    endfunction

    // Next-state logic: framing FSM, idle timeout, output handshake, sticky flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        sr_d        = sr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        byte_done_s = 1'b0;
        set_ferr_s  = 1'b0;
        set_ovr_s   = 1'b0;
        sr_shift_s  = shift_in(sr_q, in_bit);
        accept_s    = valid_q & out_ready;

        case (state_q)
            ST_IDLE: begin
                idle_d = 16'd0;
                if (in_en && in_sof) begin
                    sr_d    = sr_shift_s;
                    cnt_d   = 3'd1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = 3'd0;
                end
            end
            ST_SHIFT: begin
                if (in_en) begin
                    idle_d = 16'd0;
                    sr_d   = sr_shift_s;
                    if (in_sof) begin
                        set_ferr_s = (cnt_q != 3'd0);
                        cnt_d      = 3'd1;
                    end else begin
                        // cnt wraps 7 -> 0 as the eighth bit completes the byte
                        cnt_d       = 3'(cnt_q + 3'd1);
                        byte_done_s = (cnt_q == 3'd7);
                    end
                end else if (TO_EN && (idle_q == TO_LIM)) begin
                    set_ferr_s = (cnt_q != 3'd0);
                    cnt_d      = 3'd0;
                    idle_d     = 16'd0;
                    state_d    = ST_IDLE;
                end else if (TO_EN) begin
                    idle_d = 16'(idle_q + 16'd1);
                end else begin
                    idle_d = 16'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
                idle_d  = 16'd0;
            end
        endcase

        if (byte_done_s && (!valid_q || out_ready)) begin
            data_d  = sr_shift_s;
            valid_d = 1'b1;
        end else if (byte_done_s) begin
            set_ovr_s = 1'b1;
            valid_d   = valid_q;
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (set_ovr_s) begin
            ovr_d = 1'b1;
        end else if (clr_err) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        if (set_ferr_s) begin
            ferr_d = 1'b1;
        end else if (clr_err) begin
            ferr_d = 1'b0;
        end else begin
            ferr_d = ferr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            idle_q  <= 16'd0;
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_deser8.sv
// Bench for deser8: two instances (LSB-first/TIMEOUT=4, MSB-first/TIMEOUT=64)
// driven by the same directed stream and checked each cycle against a bit-list model.
module tb_deser8;

    logic clk = 1'b0;
    logic rst;
    logic in_bit = 1'b0, in_en = 1'b0, in_sof = 1'b0, out_ready = 1'b0, clr_err = 1'b0;

    logic [7:0] d_data [2];
    logic       d_valid[2];
    logic       d_ovr  [2];
    logic       d_ferr [2];

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    deser8 #(.MSB_FIRST(1'b0), .TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en), .in_sof(in_sof),
        .out_data(d_data[0]), .out_valid(d_valid[0]), .out_ready(out_ready),
        .overrun(d_ovr[0]), .frame_err(d_ferr[0]), .clr_err(clr_err));

    deser8 #(.MSB_FIRST(1'b1), .TIMEOUT(64)) dut1 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en), .in_sof(in_sof),
        .out_data(d_data[1]), .out_valid(d_valid[1]), .out_ready(out_ready),
        .overrun(d_ovr[1]), .frame_err(d_ferr[1]), .clr_err(clr_err));

    // Model: per instance, the list of bits received so far in the current byte.
    int         m_msb[2] = '{0, 1};
    int         m_to [2] = '{4, 64};
    bit         m_active[2];
    int         m_nb[2];
    bit         m_bits[2][8];
    int         m_idle[2];
    logic [7:0] m_data[2];
    bit         m_valid[2], m_ovr[2], m_ferr[2];

    always @(posedge clk or posedge rst) begin : model
        bit         sf, so, ld;
        logic [7:0] by;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k] = 1'b0; m_nb[k] = 0; m_idle[k] = 0;
                m_data[k] = 8'h00; m_valid[k] = 1'b0; m_ovr[k] = 1'b0; m_ferr[k] = 1'b0;
            end else begin
                sf = 1'b0; so = 1'b0; ld = 1'b0; by = 8'h00;
                if (in_en) begin
                    m_idle[k] = 0;
                    if (in_sof) begin
                        if (m_active[k] && m_nb[k] > 0) sf = 1'b1;
                        m_active[k] = 1'b1;
                        m_bits[k][0] = in_bit;
                        m_nb[k] = 1;
                    end else if (m_active[k]) begin
                        m_bits[k][m_nb[k]] = in_bit;
                        m_nb[k]++;
                        if (m_nb[k] == 8) begin
                            for (int i = 0; i < 8; i++)
                                by[(m_msb[k] != 0) ? 7 - i : i] = m_bits[k][i];
                            m_nb[k] = 0;
                            if (!m_valid[k] || out_ready) ld = 1'b1;
                            else so = 1'b1;
                        end
                    end
                end else if (m_active[k] && m_to[k] > 0) begin
                    m_idle[k]++;
                    if (m_idle[k] == m_to[k]) begin
                        if (m_nb[k] > 0) sf = 1'b1;
                        m_active[k] = 1'b0; m_nb[k] = 0; m_idle[k] = 0;
                    end
                end
                if (ld) begin
                    m_data[k] = by; m_valid[k] = 1'b1;
                end else if (m_valid[k] && out_ready) begin
                    m_valid[k] = 1'b0;
                end
                m_ovr[k]  = so ? 1'b1 : (clr_err ? 1'b0 : m_ovr[k]);
                m_ferr[k] = sf ? 1'b1 : (clr_err ? 1'b0 : m_ferr[k]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d out_data", k), 32'(d_data[k]), 32'(m_data[k]));
                check($sformatf("dut%0d out_valid", k), 32'(d_valid[k]), 32'(m_valid[k]));
                check($sformatf("dut%0d overrun", k), 32'(d_ovr[k]), 32'(m_ovr[k]));
                check($sformatf("dut%0d frame_err", k), 32'(d_ferr[k]), 32'(m_ferr[k]));
            end
        end
    end

    task automatic send(input logic b, input logic s);
        in_en = 1'b1; in_bit = b; in_sof = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_en = 1'b0; in_sof = 1'b0; in_bit = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Bit i of v is sent i-th, so the LSB-first instance reassembles v.
    task automatic send_byte(input logic [7:0] v, input logic sof);
        for (int i = 0; i < 8; i++) send(v[i], sof && (i == 0));
    endtask

    task automatic do_reset();
        in_en = 1'b0; in_sof = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset data", 32'(d_data[0]), 32'h00);
        check("reset valid", 32'(d_valid[0]), 32'h0);
        check("reset overrun", 32'(d_ovr[1]), 32'h0);
        check("reset frame_err", 32'(d_ferr[1]), 32'h0);
        rst = 1'b0;

        // Basic byte, both bit orders, then back-to-back byte without SOF
        out_ready = 1'b1;
        send_byte(8'h4D, 1'b1);
        check("lsb byte", 32'(d_data[0]), 32'h4D);
        check("msb byte", 32'(d_data[1]), 32'hB2);
        check("byte valid", 32'(d_valid[0]), 32'h1);
        send_byte(8'hFF, 1'b0);
        check("second byte", 32'(d_data[1]), 32'hFF);
        check("second valid", 32'(d_valid[1]), 32'h1);
        idle(1);
        check("valid one cycle", 32'(d_valid[0]), 32'h0);
        check("no flags", 32'({d_ovr[0], d_ferr[0]}), 32'h0);
        idle(6);

        // Overrun with stalled consumer
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        check("overrun hold data", 32'(d_data[0]), 32'h11);
        check("overrun flag", 32'(d_ovr[0]), 32'h1);
        out_ready = 1'b1;
        idle(1);
        check("accept clears valid", 32'(d_valid[0]), 32'h0);
        idle(2);

        // Short byte then framed A5; clr_err; set wins over clear
        do_reset();
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("frame_err on sof", 32'(d_ferr[0]), 32'h1);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] a5;
            a5 = 8'hA5;
            send(a5[i], 1'b0);
        end
        check("byte after short", 32'(d_data[0]), 32'hA5);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("clr_err clears", 32'(d_ferr[0]), 32'h0);
        send(1'b1, 1'b1); send(1'b0, 1'b0);
        clr_err = 1'b1;
        send(1'b1, 1'b1);
        clr_err = 1'b0;
        check("set wins over clr", 32'(d_ferr[0]), 32'h1);
        idle(8);

        // Idle timeout (dut0 TIMEOUT=4)
        do_reset();
        send(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
        idle(3);
        check("no timeout yet", 32'(d_ferr[0]), 32'h0);
        idle(1);
        check("timeout frame_err", 32'(d_ferr[0]), 32'h1);
        send_byte(8'hC3, 1'b0);
        check("ignored after timeout", 32'(d_valid[0]), 32'h0);
        idle(2);

        // Async reset mid-frame with byte pending, then clean byte
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h5A, 1'b1);
        send(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        in_en = 1'b0; in_sof = 1'b0;
        check("pending before reset", 32'(d_valid[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async rst data%0d", k), 32'(d_data[k]), 32'h00);
            check($sformatf("async rst valid%0d", k), 32'(d_valid[k]), 32'h0);
            check($sformatf("async rst flags%0d", k), 32'({d_ovr[k], d_ferr[k]}), 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send_byte(8'h3C, 1'b1);
        check("post reset byte", 32'(d_data[0]), 32'h3C);
        check("post reset valid", 32'(d_valid[0]), 32'h1);
        check("post reset flags", 32'({d_ovr[0], d_ferr[0]}), 32'h0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/deser8.md
# deser8

Serial-to-parallel byte assembler that sits directly upstream of the 8-way bit splitter. It collects a strobed serial bit stream into 8-bit words, frames them on a start-of-frame marker, and presents each completed byte on a valid/ready output bus whose `out_data` feeds the splitter's 8-bit input. It detects framing errors (short bytes, idle timeout) and output overruns, and reports both as sticky flags.

## Interface
- `MSB_FIRST`, default 0: 0 = first received bit lands in `out_data[0]`; 1 = first bit lands in `out_data[7]`.
- `TIMEOUT`, default 64: idle cycles (no `in_en`) allowed inside a frame before abort; 0 disables the timeout; legal range 0..65535.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_bit`  in  1  serial data, sampled only when `in_en`=1.
- `in_en`  in  1  bit strobe, one bit per cycle when high.
- `in_sof`  in  1  qualifies the current bit as the first bit of a byte; ignored when `in_en`=0.
- `out_data`  out  8  completed byte, held stable while `out_valid`=1.
- `out_valid`  out  1  byte available.
- `out_ready`  in  1  consumer accepts the byte when `out_valid` and `out_ready` are both high.
- `overrun`  out  1  sticky: a completed byte was dropped because the output was still full.
- `frame_err`  out  1  sticky: a partial byte was discarded.
- `clr_err`  in  1  synchronous clear of `overrun` and `frame_err`.

## Operation
- Two states:
  - IDLE: waiting for SOF.
  - SHIFT: inside a frame. It holds a 3-bit count `cnt` of bits received in the current byte.
- Shift register and output holding register are separate, so shifting continues while a byte waits on the output.
- IDLE:
  - `in_en`=1 with `in_sof`=0: bit dropped, no flag raised.
  - `in_en`=1 with `in_sof`=1: bit stored, `cnt`=1, go to SHIFT.
- SHIFT, on `in_en`=1 with `in_sof`=0: bit stored, `cnt` increments.
- SHIFT, on `in_en`=1 with `in_sof`=1:
  - If `cnt` is 1..7, set `frame_err` and discard the partial byte.
  - In all cases the strobed bit becomes bit 1 of a new byte and `cnt`=1.
- Byte complete (8th bit stored):
  - If the output is free, load the holding register. "Free" means `out_valid`=0, or `out_valid`=1 and `out_ready`=1 on the same edge.
  - Otherwise, drop the byte, set `overrun`, and leave the holding register unchanged.
  - `cnt` returns to 0 and the state stays SHIFT. Back-to-back bytes need no further SOF.
- Timeout (`TIMEOUT`>0): an idle counter runs in SHIFT, cleared on every `in_en`. When it reaches `TIMEOUT`:
  - If `cnt` is 1..7, set `frame_err` and discard the partial byte.
  - If `cnt`=0, no flag is raised.
  - In both cases, go to IDLE.
- Output handshake:
  - `out_valid` clears on accept unless a new byte loads on the same edge, in which case it stays 1 with the new data.
  - `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- Sticky flags:
  - Set and cleared only by events in this block.
  - `clr_err` clears both flags.
  - If a set event and `clr_err` occur in the same cycle, the set wins.
- Bit order follows `MSB_FIRST` exactly. No bit reversal happens anywhere else.

## Timing
- Reset values:
  - Outputs: `out_data`=8'h00, `out_valid`=0, `overrun`=0, `frame_err`=0.
  - Internal: state IDLE, `cnt`=0, idle counter 0.
- Reset mid-frame or with a byte pending discards everything and raises no flag.
- Latency:
  - The 8th bit is sampled at edge N; `out_valid`=1 with the full byte is visible after edge N.
  - The minimum byte period is 8 cycles, and output throughput keeps up if `out_ready` stays high.
- Flags assert on the edge that detects the event (registered, one cycle after the causing input).
- Timeout fires on the edge where the idle count reaches `TIMEOUT`. With `TIMEOUT`=64 and the last `in_en` at edge M, the abort happens at edge M+64. An `in_en` at edge M+64 cancels the timeout.
- No combinational path from any input to any output.

## Test plan
- Reset then SOF + bits 1,0,1,1,0,0,1,0 on consecutive cycles, `MSB_FIRST`=0, `out_ready`=1 → `out_valid` for 1 cycle after the 8th edge, `out_data`=8'h4D, flags 0.
- Same stream with `MSB_FIRST`=1 → `out_data`=8'hB2. Then 8 more bits without SOF (all 1) → second byte 8'hFF, with no SOF needed.
- `out_ready`=0, two complete bytes 8'h11 then 8'h22 → `out_data` holds 8'h11, `overrun`=1 after the 16th bit. Raise `out_ready` → 8'h11 accepted, `out_valid`=0.
- SOF + 3 bits, then SOF + 8 bits forming 8'hA5 → `frame_err`=1 on the second SOF edge, output 8'hA5. Assert `clr_err` → flag 0. Assert `clr_err` on the same cycle as a new error → flag stays 1.
- `TIMEOUT`=4: SOF + 5 bits, then `in_en` low for 4 cycles → `frame_err`=1, state IDLE. Next bits without SOF are ignored (no `out_valid`).
- Assert `rst` asynchronously with `out_valid`=1 and 6 bits shifted → all outputs to reset values immediately. A following SOF byte 8'h3C is received cleanly.
